// File: rtl/demosine_pkg.sv
// ---------------------------------------------------------------------------
// demosine_pkg : shared VGA timing defaults and sine-layer cell geometry
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package demosine_pkg;

  // 640x480@60 timing, pixel clock 25.175 MHz
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int CELL_BITS_X = 6;
  localparam int CELL_BITS_Y = 5;
  localparam int SINE_ROWS   = 22;

  localparam logic [CELL_BITS_Y-1:0] Y_BLANK = 5'd31;

endpackage

`default_nettype wire

// File: rtl/vga_raster_cnt.sv
// ---------------------------------------------------------------------------
// vga_raster_cnt : free-running h/v raster counters with a frame-end strobe
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module vga_raster_cnt
  import demosine_pkg::*;
#(
  parameter int H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP,
  parameter int V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP,
  parameter int HW      = $clog2(H_TOTAL),
  parameter int VW      = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          frame_end
);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          h_last, v_last;

  always_comb begin
    h_last  = (h_cnt_q == HW'(H_TOTAL - 1));
    v_last  = (v_cnt_q == VW'(V_TOTAL - 1));
    h_cnt_d = h_last ? '0 : h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_last) begin
      v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_cnt     = h_cnt_q;
  assign v_cnt     = v_cnt_q;
  assign frame_end = h_last && v_last;

endmodule

`default_nettype wire

// File: rtl/sine_scan_gen.sv
// ---------------------------------------------------------------------------
// sine_scan_gen : VGA scan stage mapping pixels to sine-layer cells, with
//                 optional per-frame horizontal scroll (SINE_SCAN_SCROLL_EN)
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module sine_scan_gen
  import demosine_pkg::*;
#(
  parameter int H_ACTIVE   = VGA_H_ACTIVE,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_ACTIVE   = VGA_V_ACTIVE,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter int CELL_SHIFT = 3,
  parameter int BAND_TOP   = 152,
  parameter int SCROLL_DIV = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pause,
  output logic [CELL_BITS_X-1:0] x,
  output logic [CELL_BITS_Y-1:0] y,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   display_on,
  output logic                   frame_start
);

  localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW           = $clog2(H_TOTAL);
  localparam int VW           = $clog2(V_TOTAL);
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;
  localparam int BAND_END     = BAND_TOP + (SINE_ROWS << CELL_SHIFT);

  logic [HW-1:0]          h_cnt;
  logic [VW-1:0]          v_cnt;
  logic                   frame_end;
  logic [CELL_BITS_X-1:0] scroll;
  int                     h_i, v_i;

  vga_raster_cnt #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL),
    .HW      (HW),
    .VW      (VW)
  ) u_raster (
    .clk       (clk),
    .rst       (rst),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .frame_end (frame_end)
  );

  assign h_i = int'(h_cnt);
  assign v_i = int'(v_cnt);

`ifdef SINE_SCAN_SCROLL_EN
  localparam int FW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  logic [FW-1:0]          fdiv_q, fdiv_d;
  logic [CELL_BITS_X-1:0] scroll_q, scroll_d;

  // Stepping on the last pixel means the new offset starts exactly at (0,0).
  always_comb begin
    fdiv_d   = fdiv_q;
    scroll_d = scroll_q;
    if (frame_end && !pause) begin
      if (fdiv_q == FW'(SCROLL_DIV - 1)) begin
        fdiv_d   = '0;
        scroll_d = scroll_q + 1'b1;
      end else begin
        fdiv_d   = fdiv_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fdiv_q   <= '0;
      scroll_q <= '0;
    end else begin
      fdiv_q   <= fdiv_d;
      scroll_q <= scroll_d;
    end
  end

  assign scroll = scroll_q;
`else
  logic unused_scroll_inputs;
  assign unused_scroll_inputs = ^{pause, frame_end};
  assign scroll = '0;
`endif

  logic [CELL_BITS_X-1:0] x_q, x_d;
  logic [CELL_BITS_Y-1:0] y_q, y_d;
  logic                   hsync_q, hsync_d;
  logic                   vsync_q, vsync_d;
  logic                   display_on_q, display_on_d;
  logic                   frame_start_q, frame_start_d;

  always_comb begin
    display_on_d  = (h_i < H_ACTIVE) && (v_i < V_ACTIVE);
    hsync_d       = !((h_i >= H_SYNC_START) && (h_i < H_SYNC_END));
    vsync_d       = !((v_i >= V_SYNC_START) && (v_i < V_SYNC_END));
    frame_start_d = (h_i == 0) && (v_i == 0);
    x_d           = CELL_BITS_X'(h_i >> CELL_SHIFT) + scroll;
    // Y_BLANK selects the sine layer's black row, so no downstream gating.
    y_d           = Y_BLANK;
    if (display_on_d && (v_i >= BAND_TOP) && (v_i < BAND_END)) begin
      y_d = CELL_BITS_Y'((v_i - BAND_TOP) >> CELL_SHIFT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q           <= '0;
      y_q           <= Y_BLANK;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      display_on_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      display_on_q  <= display_on_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign display_on  = display_on_q;
  assign frame_start = frame_start_q;

endmodule

`default_nettype wire

// File: doc/sine_scan_gen.md
# sine_scan_gen

Upstream scan stage for the sine demo layer. Runs the 640x480@60 VGA raster from the pixel clock, produces VGA sync pins, and maps each pixel to the sine layer's 6-bit cell column `x` and 5-bit cell row `y`. It also scrolls the wave horizontally once per configurable number of frames. All outputs are registered, so the combinational sine layer output lines up with this block's sync/enable outputs.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP` / `H_SYNC` / `H_BP`, 16 / 96 / 48, horizontal porch and sync widths
- `V_ACTIVE`, 480, visible lines
- `V_FP` / `V_SYNC` / `V_BP`, 10 / 2 / 33, vertical porch and sync widths
- `CELL_SHIFT`, 3, log2 of cell size in pixels (both axes)
- `BAND_TOP`, 152, first visible line of the 22-row sine band
- `SCROLL_DIV`, 2, frames per scroll step (>=1)
- `clk`  in  1  pixel clock (25.175 MHz); the block's only clock
- `rst`  in  1  reset; asynchronous, active-high
- `pause`  in  1  freezes scroll while high; raster keeps running
- `x`  out  6  cell column for the sine layer
- `y`  out  5  cell row for the sine layer; 31 = blank row
- `hsync`  out  1  pin level, low during the horizontal sync pulse
- `vsync`  out  1  pin level, low during the vertical sync pulse
- `display_on`  out  1  high in the visible area
- `frame_start`  out  1  one-cycle pulse with pixel (0,0)

## Operation
- `h_cnt` counts 0..799 and wraps. `v_cnt` counts 0..524 and advances when `h_cnt` wraps. Totals are derived from the parameters.
- Registered outputs for each counter pair (h, v):
  - `display_on` = h<640 && v<480
  - `hsync` = !(656<=h<752)
  - `vsync` = !(490<=v<492)
  - `frame_start` = (h==0 && v==0)
- `x` = ((h >> CELL_SHIFT) + scroll) mod 64, computed in every region.
- `y` = (v − BAND_TOP) >> CELL_SHIFT when display_on and BAND_TOP <= v < BAND_TOP + (22 << CELL_SHIFT). Otherwise `y` = 31. Row 31 hits the sine layer's black default, so blanking needs no extra gating downstream.
- Scroll uses a 6-bit `scroll` register and a frame divider `fdiv` (0..SCROLL_DIV−1).
  - At the last pixel (h=799, v=524), with `pause` low: `fdiv` increments.
  - On reaching SCROLL_DIV−1, `fdiv` returns to 0 and `scroll` increments mod 64 (63→0).
  - With `pause` high, `fdiv` and `scroll` hold.
- A new `scroll` value is first visible in the `x` output that accompanies `frame_start`. It never changes mid-frame.

## Timing
- Latency is 1 cycle: the outputs after a clock edge describe the counter values held before that edge.
- Reset values: `h_cnt`=0, `v_cnt`=0, `fdiv`=0, `scroll`=0, `x`=0, `y`=31, `hsync`=1, `vsync`=1, `display_on`=0, `frame_start`=0.
- First edge after reset release: outputs for (0,0), so `frame_start`=1, `display_on`=1, `y`=31.
- Reset asserted mid-frame: all state clears immediately (asynchronously) and the raster restarts at (0,0). No partial-frame scroll step occurs.
- `pause` is sampled only at the frame-end pixel. Toggling it mid-frame has no effect.
- Wrap-around: `x` wraps 63→0 within a line (h>>3 reaches 79). The sine layer treats this as the next period.

## Configuration
- `SINE_SCAN_SCROLL_EN` defined: scroll logic as above.
- Undefined: `scroll` and `fdiv` are removed, `scroll` is the constant 0, `x` = (h >> CELL_SHIFT) mod 64, and `pause` is ignored (tie it off as unused).

## Structure
- Shared package `demosine_pkg` holds:
  - VGA timing defaults
  - `Y_BLANK` = 5'd31
  - `SINE_ROWS` = 22
  - `CELL_BITS_X` = 6, `CELL_BITS_Y` = 5
- Sub-module `vga_raster_cnt` contains the h/v counters with a frame-end strobe. It is reusable by other demo layers.
- This block adds the cell mapping, scroll, and output registers.

## Test plan
- Reset release → first edge `frame_start`=1, `x`=0, `y`=31; `hsync` low exactly cycles 656..751 of each line; `vsync` low for lines 490–491 only.
- Line v=152, h=0..7 → `y`=0 and `x`=0; h=8 → `x`=1; v=327 → `y`=21; v=328 and v=151 → `y`=31.
- h=512 (cell 64) with scroll=0 → `x`=0; h=640..799 → `display_on`=0, `y`=31.
- SCROLL_DIV=2, `pause`=0: frame 0 and frame 1 `x`@h=0 is 0; frame 2 shows 1; after 128 frames `scroll` wraps to 0.
- `pause` high across frame-end → `scroll` unchanged next frame; `pause` pulsed mid-frame only → scroll steps normally.
- Reset asserted at (300,200) → outputs take reset values asynchronously; after release the raster restarts at (0,0) with `scroll`=0; with `SINE_SCAN_SCROLL_EN` undefined, `x`@h=0 stays 0 on every frame.
